// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared constants and types for the littletoe TCP engine
//
// Frame layout offsets, protocol constants, TCP flag masks, transmit FSM
// states and the latched request record. Used by both tcp_tx and the
// receive engine.
package tcp_pkg;

    // Byte offsets inside an Ethernet II / IPv4 / TCP frame (no options)
    localparam int ETH_OFF   = 0;
    localparam int IP_OFF    = 14;
    localparam int TCP_OFF   = 34;
    localparam int HDR_LEN   = 54;
    localparam int MIN_FRAME = 60;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP      = 8'h06;
    localparam logic [10:0] MAX_PAYLOAD    = 11'd1460;

    // TCP flag byte, bit 7 (CWR) down to bit 0 (FIN)
    localparam logic [7:0] FLAG_FIN = 8'h01;
    localparam logic [7:0] FLAG_SYN = 8'h02;
    localparam logic [7:0] FLAG_RST = 8'h04;
    localparam logic [7:0] FLAG_PSH = 8'h08;
    localparam logic [7:0] FLAG_ACK = 8'h10;
    localparam logic [7:0] FLAG_URG = 8'h20;
    localparam logic [7:0] FLAG_ECE = 8'h40;
    localparam logic [7:0] FLAG_CWR = 8'h80;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_CSUM1,
        TX_CSUM2,
        TX_HDR,
        TX_PAYLOAD,
        TX_PAD
    } tx_state_e;

    // Per-frame request fields captured when a request is accepted
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
        logic [15:0] window;
        logic [10:0] len;
        logic [15:0] pay_csum;
    } tx_req_t;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        return (len > MAX_PAYLOAD) ? MAX_PAYLOAD : len;
    endfunction

endpackage

// File: rtl/csum16_fold.sv
// rtl/csum16_fold.sv - combinational 32-to-16-bit one's-complement fold
//
// Ports:
//   sum_i  in  32  raw sum of 16-bit words
//   fold_o out 16  end-around-carry folded sum (not complemented)
module csum16_fold (
    input  logic [31:0] sum_i,
    output logic [15:0] fold_o
);

    logic [16:0] fold1;
    logic [15:0] fold2;

    // The second fold cannot carry out: when the first fold carries, its
    // low half is at most 0xFFFE.
    always_comb begin
        fold1  = {1'b0, sum_i[31:16]} + {1'b0, sum_i[15:0]};
        fold2  = fold1[15:0] + {15'h0, fold1[16]};
        fold_o = fold2;
    end

endmodule

// File: rtl/tcp_tx.sv
// rtl/tcp_tx.sv - TCP transmit engine: one Ethernet/IPv4/TCP frame per request
//
// Ports:
//   CLOCK, RESET_N            clock (rising edge), async active-low reset
//   start / startReady        frame request handshake (ready only in IDLE)
//   dstMac..payloadCsum       per-frame request fields, latched on accept
//   inData/inValid/inReady    payload byte stream from upstream
//   outData/outDataValid/outReady  frame byte stream to the sink
//   newpkt, outLast           first / final byte markers, held with outData
module tcp_tx
    import tcp_pkg::*;
#(
    parameter logic [15:0] port = 16'd80,
    parameter logic [47:0] mac  = 48'hC471FEC856BF,
    parameter logic [31:0] ip   = 32'hC0A80002,
    parameter logic [7:0]  ttl  = 8'd64
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        start,
    output logic        startReady,
    input  logic [47:0] dstMac,
    input  logic [31:0] dstIp,
    input  logic [15:0] dstPort,
    input  logic [31:0] seq,
    input  logic [31:0] ack,
    input  logic [7:0]  flags,
    input  logic [15:0] window,
    input  logic [10:0] payloadLen,
    input  logic [15:0] payloadCsum,
    input  logic [7:0]  inData,
    input  logic        inValid,
    output logic        inReady,
    output logic [7:0]  outData,
    output logic        outDataValid,
    input  logic        outReady,
    output logic        newpkt,
    output logic        outLast
);

    tx_state_e   state_q, state_d;
    tx_req_t     req_q, req_d;
    logic [15:0] ip_id_q, ip_id_d;
    logic [31:0] ip_sum_q, ip_sum_d;
    logic [31:0] tcp_sum_q, tcp_sum_d;
    logic [15:0] ip_csum_q, ip_csum_d;
    logic [15:0] tcp_csum_q, tcp_csum_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [10:0] rem_q, rem_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        newpkt_q, newpkt_d;
    logic        last_q, last_d;

    logic        advance;
    logic [15:0] tot_len;
    logic [15:0] tcp_len;
    logic [31:0] ip_sum_raw;
    logic [31:0] tcp_sum_raw;
    logic [15:0] ip_fold;
    logic [15:0] tcp_fold;
    logic [HDR_LEN*8-1:0] hdr_bits;
    logic [HDR_LEN*8-1:0] hdr_shift;
    logic [7:0]  hdr_byte;

    csum16_fold u_ip_fold  (.sum_i(ip_sum_q),  .fold_o(ip_fold));
    csum16_fold u_tcp_fold (.sum_i(tcp_sum_q), .fold_o(tcp_fold));

    always_comb begin
        tot_len = 16'd40 + {5'd0, req_q.len};
        tcp_len = 16'd20 + {5'd0, req_q.len};

        ip_sum_raw = 32'(16'h4500) + 32'(tot_len) + 32'(ip_id_q) + 32'(16'h4000)
                   + 32'({ttl, PROTO_TCP})
                   + 32'(ip[31:16]) + 32'(ip[15:0])
                   + 32'(req_q.dst_ip[31:16]) + 32'(req_q.dst_ip[15:0]);

        // Pseudo-header, TCP header (checksum and urgent fields are zero)
        // and the requester's payload sum.
        tcp_sum_raw = 32'(ip[31:16]) + 32'(ip[15:0])
                    + 32'(req_q.dst_ip[31:16]) + 32'(req_q.dst_ip[15:0])
                    + 32'({8'h00, PROTO_TCP}) + 32'(tcp_len)
                    + 32'(port) + 32'(req_q.dst_port)
                    + 32'(req_q.seq[31:16]) + 32'(req_q.seq[15:0])
                    + 32'(req_q.ack[31:16]) + 32'(req_q.ack[15:0])
                    + 32'({8'h50, req_q.flags}) + 32'(req_q.window)
                    + 32'(req_q.pay_csum);

        hdr_bits = {req_q.dst_mac, mac, ETHERTYPE_IPV4,
                    8'h45, 8'h00, tot_len, ip_id_q, 16'h4000, ttl, PROTO_TCP,
                    ip_csum_q, ip, req_q.dst_ip,
                    port, req_q.dst_port, req_q.seq, req_q.ack,
                    8'h50, req_q.flags, req_q.window, tcp_csum_q, 16'h0000};
        hdr_shift = hdr_bits << {cnt_q, 3'b000};
        hdr_byte  = hdr_shift[HDR_LEN*8-1 -: 8];
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ip_id_d     = ip_id_q;
        ip_sum_d    = ip_sum_q;
        tcp_sum_d   = tcp_sum_q;
        ip_csum_d   = ip_csum_q;
        tcp_csum_d  = tcp_csum_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        newpkt_d    = newpkt_q;
        last_d      = last_q;
        startReady  = (state_q == TX_IDLE);
        inReady     = 1'b0;
        // The output register may take a new byte when empty or being drained
        advance     = !out_valid_q || outReady;

        if (out_valid_q && last_q) begin
            // Final byte presented: wait for the sink, then close the frame
            if (outReady) begin
                state_d     = TX_IDLE;
                out_valid_d = 1'b0;
                newpkt_d    = 1'b0;
                last_d      = 1'b0;
                ip_id_d     = ip_id_q + 16'd1;
            end
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    if (start) begin
                        req_d.dst_mac  = dstMac;
                        req_d.dst_ip   = dstIp;
                        req_d.dst_port = dstPort;
                        req_d.seq      = seq;
                        req_d.ack      = ack;
                        req_d.flags    = flags;
                        req_d.window   = window;
                        req_d.len      = clamp_len(payloadLen);
                        req_d.pay_csum = payloadCsum;
                        state_d        = TX_CSUM1;
                    end
                end
                TX_CSUM1: begin
                    ip_sum_d  = ip_sum_raw;
                    tcp_sum_d = tcp_sum_raw;
                    state_d   = TX_CSUM2;
                end
                TX_CSUM2: begin
                    ip_csum_d  = ~ip_fold;
                    tcp_csum_d = ~tcp_fold;
                    cnt_d      = 6'd0;
                    rem_d      = req_q.len;
                    state_d    = TX_HDR;
                end
                TX_HDR: begin
                    if (advance) begin
                        out_data_d  = hdr_byte;
                        out_valid_d = 1'b1;
                        newpkt_d    = (cnt_q == 6'd0);
                        last_d      = 1'b0;
                        cnt_d       = cnt_q + 6'd1;
                        if (cnt_q == 6'(HDR_LEN - 1)) begin
                            state_d = (req_q.len == 11'd0) ? TX_PAD : TX_PAYLOAD;
                        end
                    end
                end
                TX_PAYLOAD: begin
                    inReady = advance;
                    if (advance) begin
                        newpkt_d = 1'b0;
                        if (inValid) begin
                            out_data_d  = inData;
                            out_valid_d = 1'b1;
                            rem_d       = rem_q - 11'd1;
                            if (rem_q == 11'd1) begin
                                if (req_q.len < 11'(MIN_FRAME - HDR_LEN)) begin
                                    // Short payload: continue byte count in PAD
                                    state_d = TX_PAD;
                                    cnt_d   = 6'(HDR_LEN) + req_q.len[5:0];
                                end else begin
                                    last_d = 1'b1;
                                end
                            end
                        end else begin
                            // Upstream bubble passes straight through
                            out_valid_d = 1'b0;
                        end
                    end
                end
                TX_PAD: begin
                    if (advance) begin
                        out_data_d  = 8'h00;
                        out_valid_d = 1'b1;
                        newpkt_d    = 1'b0;
                        last_d      = (cnt_q == 6'(MIN_FRAME - 1));
                        cnt_d       = cnt_q + 6'd1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= TX_IDLE;
            req_q       <= '0;
            ip_id_q     <= 16'd0;
            ip_sum_q    <= 32'd0;
            tcp_sum_q   <= 32'd0;
            ip_csum_q   <= 16'd0;
            tcp_csum_q  <= 16'd0;
            cnt_q       <= 6'd0;
            rem_q       <= 11'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            newpkt_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ip_id_q     <= ip_id_d;
            ip_sum_q    <= ip_sum_d;
            tcp_sum_q   <= tcp_sum_d;
            ip_csum_q   <= ip_csum_d;
            tcp_csum_q  <= tcp_csum_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            newpkt_q    <= newpkt_d;
            last_q      <= last_d;
        end
    end

    assign outData      = out_data_q;
    assign outDataValid = out_valid_q;
    assign newpkt       = newpkt_q;
    assign outLast      = last_q;

endmodule
